// File: rtl/chunked_seq_adder_if.sv
// Operand/result handshake bundle for chunked_seq_adder.
// master drives operands and out_ready; slave (the adder) drives in_ready and the result.
`timescale 1ns/1ps
interface chunked_seq_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/chunked_seq_adder.sv
// Sequential adder/subtractor, CHUNK bits per cycle; result valid WIDTH/CHUNK cycles after accept.
// One op in flight: in_ready only in IDLE, result held in DONE until out_ready.
`timescale 1ns/1ps
module chunked_seq_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    chunked_seq_adder_if.slave   bus
);
    if (WIDTH < 1 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_param
        $error("chunked_seq_adder: WIDTH must be a positive multiple of CHUNK");
    end

    localparam int N  = WIDTH / CHUNK;
    localparam int KW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic [KW-1:0]    k_q, k_d;

    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic [CHUNK:0]   chunk_res;
    logic             msb_cin;
    logic             last_chunk;
    logic             accept;

    assign accept     = (state_q == IDLE) && bus.in_valid;
    assign last_chunk = (k_q == KW'(N - 1));

    always_comb begin
        a_chunk   = a_q[int'(k_q) * CHUNK +: CHUNK];
        b_chunk   = b_q[int'(k_q) * CHUNK +: CHUNK];
        chunk_res = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_q};
        // On the last chunk this is the carry into bit WIDTH-1, needed for signed overflow.
        msb_cin   = a_chunk[CHUNK-1] ^ b_chunk[CHUNK-1] ^ chunk_res[CHUNK-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.in_valid)  state_d = RUN;
            RUN:     if (last_chunk)    state_d = DONE;
            DONE:    if (bus.out_ready) state_d = IDLE;
            default:                    state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = (state_q == IDLE);
        bus.out_valid = (state_q == DONE);
    end

    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        k_d     = k_q;
        if (accept) begin
            a_d     = bus.a;
            b_d     = bus.sub ? ~bus.b : bus.b;
            carry_d = bus.sub | bus.cin;
            k_d     = '0;
        end else if (state_q == RUN) begin
            sum_d[int'(k_q) * CHUNK +: CHUNK] = chunk_res[CHUNK-1:0];
            carry_d = chunk_res[CHUNK];
            k_d     = k_q + 1'b1;
            if (last_chunk) begin
                cout_d = chunk_res[CHUNK];
                ovf_d  = msb_cin ^ chunk_res[CHUNK];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            k_q     <= '0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            k_q     <= k_d;
        end
    end

    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
    assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_chunked_seq_adder.sv
// Directed checks of chunked_seq_adder at 16/4 and 1/1 geometries.
`timescale 1ns/1ps
module tb_chunked_seq_adder;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    chunked_seq_adder_if #(.WIDTH(16)) if16 ();
    chunked_seq_adder_if #(.WIDTH(1))  if1 ();

    chunked_seq_adder #(.WIDTH(16), .CHUNK(4)) u_dut16 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if16)
    );

    chunked_seq_adder #(.WIDTH(1), .CHUNK(1)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if1)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at a negedge with the block back in IDLE.
    task automatic run16(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic cin, input logic sub, input int stall,
                         input logic [15:0] es, input logic ec, input logic eo);
        int lat;
        if16.a = a; if16.b = b; if16.cin = cin; if16.sub = sub;
        if16.in_valid = 1'b1;
        chk({tag, ".rdy"}, 32'(if16.in_ready), 32'd1);
        @(posedge clk); #1;
        if16.in_valid = 1'b0;
        if16.a = ~a; if16.b = 16'h5A5A; if16.cin = ~cin; if16.sub = ~sub;
        lat = 0;
        while (!if16.out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, ".lat"}, 32'(lat), 32'd4);
        chk({tag, ".sum"}, 32'(if16.sum), 32'(es));
        chk({tag, ".cout"}, 32'(if16.cout), 32'(ec));
        chk({tag, ".ovf"}, 32'(if16.ovf), 32'(eo));
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            if16.in_valid = 1'b1;
            if16.a = 16'h1111; if16.b = 16'h2222; if16.sub = 1'b0;
            @(posedge clk); #1;
            if16.in_valid = 1'b0;
            chk({tag, ".stall_vld"}, 32'(if16.out_valid), 32'd1);
            chk({tag, ".stall_rdy"}, 32'(if16.in_ready), 32'd0);
            chk({tag, ".stall_sum"}, 32'(if16.sum), 32'(es));
        end
        if16.out_ready = 1'b1;
        @(posedge clk); #1;
        if16.out_ready = 1'b0;
        chk({tag, ".idle_rdy"}, 32'(if16.in_ready), 32'd1);
        chk({tag, ".idle_vld"}, 32'(if16.out_valid), 32'd0);
        chk({tag, ".idle_sum"}, 32'(if16.sum), 32'(es));
        @(negedge clk);
    endtask

    task automatic run1(input logic a, input logic b, input logic cin, input logic [1:0] exp);
        int lat;
        if1.a = a; if1.b = b; if1.cin = cin; if1.sub = 1'b0;
        if1.in_valid = 1'b1;
        @(posedge clk); #1;
        if1.in_valid = 1'b0;
        lat = 0;
        while (!if1.out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk($sformatf("w1_%0d%0d%0d.lat", a, b, cin), 32'(lat), 32'd1);
        chk($sformatf("w1_%0d%0d%0d.res", a, b, cin), 32'({if1.cout, if1.sum}), 32'(exp));
        chk($sformatf("w1_%0d%0d%0d.ovf", a, b, cin), 32'(if1.ovf), 32'(cin ^ exp[1]));
        if1.out_ready = 1'b1;
        @(posedge clk); #1;
        if1.out_ready = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int seen;
        rst_n = 1'b0;
        if16.in_valid = 1'b0; if16.out_ready = 1'b0;
        if16.a = '0; if16.b = '0; if16.cin = 1'b0; if16.sub = 1'b0;
        if1.in_valid = 1'b0; if1.out_ready = 1'b0;
        if1.a = '0; if1.b = '0; if1.cin = 1'b0; if1.sub = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst.rdy", 32'(if16.in_ready), 32'd1);
        chk("rst.vld", 32'(if16.out_valid), 32'd0);
        chk("rst.sum", 32'(if16.sum), 32'd0);
        chk("rst.cout", 32'(if16.cout), 32'd0);
        chk("rst.ovf", 32'(if16.ovf), 32'd0);

        // Accept on the very first edge after release.
        rst_n = 1'b1;
        run16("wrap",   16'hFFFF, 16'h0001, 1'b0, 1'b0, 0, 16'h0000, 1'b1, 1'b0);
        run16("sovf",   16'h7FFF, 16'h0001, 1'b0, 1'b0, 0, 16'h8000, 1'b0, 1'b1);
        run16("cin",    16'h1234, 16'h4321, 1'b1, 1'b0, 0, 16'h5556, 1'b0, 1'b0);
        run16("ripple", 16'h00FF, 16'h0001, 1'b0, 1'b0, 0, 16'h0100, 1'b0, 1'b0);
        run16("sub_neg",16'h0005, 16'h0007, 1'b1, 1'b1, 0, 16'hFFFE, 1'b0, 1'b0);
        run16("sub_pos",16'h0007, 16'h0005, 1'b1, 1'b1, 0, 16'h0002, 1'b1, 1'b0);
        run16("stall",  16'h0F0F, 16'h1010, 1'b0, 1'b0, 3, 16'h1F1F, 1'b0, 1'b0);
        run16("sub_ovf",16'h8000, 16'h0001, 1'b0, 1'b1, 0, 16'h7FFF, 1'b1, 1'b1);

        // Abort mid-RUN with a reset two cycles after acceptance.
        if16.a = 16'h1234; if16.b = 16'h1111; if16.cin = 1'b0; if16.sub = 1'b0;
        if16.in_valid = 1'b1;
        @(posedge clk); #1;
        if16.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("abort.vld", 32'(if16.out_valid), 32'd0);
        chk("abort.sum", 32'(if16.sum), 32'd0);
        chk("abort.cout", 32'(if16.cout), 32'd0);
        chk("abort.ovf", 32'(if16.ovf), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk("abort.rdy", 32'(if16.in_ready), 32'd1);
        seen = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (if16.out_valid) seen++;
        end
        chk("abort.stale", 32'(seen), 32'd0);
        chk("abort.rdy2", 32'(if16.in_ready), 32'd1);
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            v = 3'(i);
            run1(v[2], v[1], v[0], 2'(v[2]) + 2'(v[1]) + 2'(v[0]));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end
endmodule
